// File: rtl/video_mnist_pkg.sv
// Shared constants, types and elaboration helpers for the MNIST result-stream blocks.
package video_mnist_pkg;

  localparam int unsigned DEF_NUM_CLASS   = 10;
  localparam int unsigned DEF_SCORE_WIDTH = 8;
  localparam int unsigned DEF_CLASS_WIDTH = 4;

  localparam logic [DEF_CLASS_WIDTH-1:0] CLASS_REJECT = {DEF_CLASS_WIDTH{1'b1}};

  typedef logic [DEF_SCORE_WIDTH-1:0] score_t;
  typedef logic [DEF_CLASS_WIDTH-1:0] class_t;

  // Ceiling log2; clog2(1) = 0.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  // Number of surviving candidates after lvl pairwise-max levels.
  function automatic int unsigned level_count(input int unsigned n, input int unsigned lvl);
    return (n + (32'd1 << lvl) - 32'd1) >> lvl;
  endfunction

endpackage

// File: rtl/video_mnist_argmax_cmp.sv
// Registered two-input {class,score} max stage; the lower-index input (a) wins ties.
module video_mnist_argmax_cmp
  import video_mnist_pkg::*;
#(
  parameter int unsigned SCORE_WIDTH = DEF_SCORE_WIDTH,
  parameter int unsigned CLASS_WIDTH = DEF_CLASS_WIDTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cke,
  input  logic [CLASS_WIDTH-1:0] a_class,
  input  logic [SCORE_WIDTH-1:0] a_score,
  input  logic [CLASS_WIDTH-1:0] b_class,
  input  logic [SCORE_WIDTH-1:0] b_score,
  output logic [CLASS_WIDTH-1:0] y_class,
  output logic [SCORE_WIDTH-1:0] y_score
);

  logic [CLASS_WIDTH-1:0] max_class_d, max_class_q;
  logic [SCORE_WIDTH-1:0] max_score_d, max_score_q;

  always_comb begin
    max_class_d = a_class;
    max_score_d = a_score;
    if (b_score > a_score) begin
      max_class_d = b_class;
      max_score_d = b_score;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      max_class_q <= '0;
      max_score_q <= '0;
    end else if (cke) begin
      max_class_q <= max_class_d;
      max_score_q <= max_score_d;
    end
  end

  assign y_class = max_class_q;
  assign y_score = max_score_q;

endmodule

// File: rtl/video_mnist_argmax.sv
// Per-pixel argmax over class scores with threshold reject, AXI4-Stream in/out.
// Optional per-class frame histogram enabled by `VIDEO_MNIST_ARGMAX_HIST_EN.
module video_mnist_argmax
  import video_mnist_pkg::*;
#(
  parameter int unsigned TUSER_WIDTH   = 1,
  parameter int unsigned NUM_CLASS     = DEF_NUM_CLASS,
  parameter int unsigned SCORE_WIDTH   = DEF_SCORE_WIDTH,
  parameter int unsigned S_TDATA_WIDTH = NUM_CLASS * SCORE_WIDTH,
  parameter int unsigned CLASS_WIDTH   = DEF_CLASS_WIDTH,
  parameter int unsigned HIST_WIDTH    = 20
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [SCORE_WIDTH-1:0]          param_threshold,
  input  logic [TUSER_WIDTH-1:0]          s_axi4s_tuser,
  input  logic                            s_axi4s_tlast,
  input  logic [S_TDATA_WIDTH-1:0]        s_axi4s_tdata,
  input  logic                            s_axi4s_tvalid,
  output logic                            s_axi4s_tready,
  output logic [TUSER_WIDTH-1:0]          m_axi4s_tuser,
  output logic                            m_axi4s_tlast,
  output logic [CLASS_WIDTH-1:0]          m_axi4s_tclass,
  output logic [SCORE_WIDTH-1:0]          m_axi4s_tscore,
  output logic                            m_axi4s_tvalid,
  input  logic                            m_axi4s_tready,
  output logic [NUM_CLASS*HIST_WIDTH-1:0] hist_data,
  output logic                            hist_valid
);

  localparam int unsigned LEVELS = clog2(NUM_CLASS);
  localparam logic [CLASS_WIDTH-1:0] REJECT = {CLASS_WIDTH{1'b1}};

  logic cke;
  logic m_tvalid_q, m_tvalid_d;

  assign cke            = ~m_tvalid_q | m_axi4s_tready;
  assign s_axi4s_tready = cke;

  // Compare tree: level 0 is the raw input, each further level is one register stage.
  for (genvar l = 0; l <= LEVELS; l++) begin : g_lvl
    localparam int unsigned N = level_count(NUM_CLASS, l);
    logic [SCORE_WIDTH-1:0] lvl_score [N];
    logic [CLASS_WIDTH-1:0] lvl_class [N];
    if (l == 0) begin : g_in
      for (genvar j = 0; j < N; j++) begin : g_leaf
        assign lvl_score[j] = s_axi4s_tdata[j*SCORE_WIDTH +: SCORE_WIDTH];
        assign lvl_class[j] = CLASS_WIDTH'(j);
      end
    end else begin : g_node
      localparam int unsigned NP = level_count(NUM_CLASS, l - 1);
      for (genvar j = 0; j < N; j++) begin : g_cmp
        logic [SCORE_WIDTH-1:0] b_score;
        logic [CLASS_WIDTH-1:0] b_class;
        if (2 * j + 1 < NP) begin : g_pair
          assign b_score = g_lvl[l-1].lvl_score[2*j+1];
          assign b_class = g_lvl[l-1].lvl_class[2*j+1];
        end else begin : g_pass
          // Zero score never wins a strict compare, so the odd leftover passes through.
          assign b_score = '0;
          assign b_class = '0;
        end
        video_mnist_argmax_cmp #(
          .SCORE_WIDTH (SCORE_WIDTH),
          .CLASS_WIDTH (CLASS_WIDTH)
        ) u_cmp (
          .clk     (clk),
          .reset   (reset),
          .cke     (cke),
          .a_class (g_lvl[l-1].lvl_class[2*j]),
          .a_score (g_lvl[l-1].lvl_score[2*j]),
          .b_class (b_class),
          .b_score (b_score),
          .y_class (lvl_class[j]),
          .y_score (lvl_score[j])
        );
      end
    end
  end

  logic [SCORE_WIDTH-1:0] root_score;
  logic [CLASS_WIDTH-1:0] root_class;
  assign root_score = g_lvl[LEVELS].lvl_score[0];
  assign root_class = g_lvl[LEVELS].lvl_class[0];

  // Sideband and per-beat threshold travel alongside the tree levels.
  logic [LEVELS-1:0]      vld_q, vld_d;
  logic [LEVELS-1:0]      last_q, last_d;
  logic [TUSER_WIDTH-1:0] user_q [LEVELS];
  logic [TUSER_WIDTH-1:0] user_d [LEVELS];
  logic [SCORE_WIDTH-1:0] thr_q  [LEVELS];
  logic [SCORE_WIDTH-1:0] thr_d  [LEVELS];

  always_comb begin
    vld_d     = vld_q;
    last_d    = last_q;
    user_d    = user_q;
    thr_d     = thr_q;
    vld_d[0]  = s_axi4s_tvalid;
    last_d[0] = s_axi4s_tlast;
    user_d[0] = s_axi4s_tuser;
    thr_d[0]  = param_threshold;
    for (int unsigned k = 1; k < LEVELS; k++) begin
      vld_d[k]  = vld_q[k-1];
      last_d[k] = last_q[k-1];
      user_d[k] = user_q[k-1];
      thr_d[k]  = thr_q[k-1];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q  <= '0;
      last_q <= '0;
      for (int unsigned k = 0; k < LEVELS; k++) begin
        user_q[k] <= '0;
        thr_q[k]  <= '0;
      end
    end else if (cke) begin
      vld_q  <= vld_d;
      last_q <= last_d;
      user_q <= user_d;
      thr_q  <= thr_d;
    end
  end

  logic [TUSER_WIDTH-1:0] m_tuser_q, m_tuser_d;
  logic                   m_tlast_q, m_tlast_d;
  logic [CLASS_WIDTH-1:0] m_tclass_q, m_tclass_d;
  logic [SCORE_WIDTH-1:0] m_tscore_q, m_tscore_d;

  // Final stage: threshold reject.
  always_comb begin
    m_tvalid_d = vld_q[LEVELS-1];
    m_tuser_d  = user_q[LEVELS-1];
    m_tlast_d  = last_q[LEVELS-1];
    m_tscore_d = root_score;
    m_tclass_d = root_class;
    if (root_score < thr_q[LEVELS-1]) m_tclass_d = REJECT;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      m_tvalid_q <= 1'b0;
      m_tuser_q  <= '0;
      m_tlast_q  <= 1'b0;
      m_tclass_q <= '0;
      m_tscore_q <= '0;
    end else if (cke) begin
      m_tvalid_q <= m_tvalid_d;
      m_tuser_q  <= m_tuser_d;
      m_tlast_q  <= m_tlast_d;
      m_tclass_q <= m_tclass_d;
      m_tscore_q <= m_tscore_d;
    end
  end

  assign m_axi4s_tvalid = m_tvalid_q;
  assign m_axi4s_tuser  = m_tuser_q;
  assign m_axi4s_tlast  = m_tlast_q;
  assign m_axi4s_tclass = m_tclass_q;
  assign m_axi4s_tscore = m_tscore_q;

`ifdef VIDEO_MNIST_ARGMAX_HIST_EN
  logic [HIST_WIDTH-1:0]           cnt_q [NUM_CLASS];
  logic [HIST_WIDTH-1:0]           cnt_d [NUM_CLASS];
  logic [NUM_CLASS*HIST_WIDTH-1:0] hist_data_q, hist_data_d;
  logic                            hist_valid_q, hist_valid_d;
  logic                            seen_q, seen_d;
  logic                            xfer;

  assign xfer = m_tvalid_q & m_axi4s_tready;

  // Start of frame publishes the previous frame's counts, then counting restarts.
  always_comb begin
    cnt_d        = cnt_q;
    hist_data_d  = hist_data_q;
    hist_valid_d = 1'b0;
    seen_d       = seen_q;
    if (xfer) begin
      if (m_tuser_q[0]) begin
        if (seen_q) begin
          for (int unsigned k = 0; k < NUM_CLASS; k++) begin
            hist_data_d[k*HIST_WIDTH +: HIST_WIDTH] = cnt_q[k];
          end
          hist_valid_d = 1'b1;
        end
        seen_d = 1'b1;
        for (int unsigned k = 0; k < NUM_CLASS; k++) cnt_d[k] = '0;
      end
      for (int unsigned k = 0; k < NUM_CLASS; k++) begin
        if (m_tclass_q != REJECT && m_tclass_q == CLASS_WIDTH'(k) && cnt_d[k] != '1) begin
          cnt_d[k] = cnt_d[k] + HIST_WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned k = 0; k < NUM_CLASS; k++) cnt_q[k] <= '0;
      hist_data_q  <= '0;
      hist_valid_q <= 1'b0;
      seen_q       <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      hist_data_q  <= hist_data_d;
      hist_valid_q <= hist_valid_d;
      seen_q       <= seen_d;
    end
  end

  assign hist_data  = hist_data_q;
  assign hist_valid = hist_valid_q;
`else
  assign hist_data  = '0;
  assign hist_valid = 1'b0;
`endif

endmodule

// File: tb/tb_video_mnist_argmax.sv
// Scoreboard bench for video_mnist_argmax; histogram test runs when VIDEO_MNIST_ARGMAX_HIST_EN is defined.
module tb_video_mnist_argmax;

  localparam int unsigned NC = 10;
  localparam int unsigned SW = 8;
  localparam int unsigned CW = 4;
  localparam int unsigned HW = 20;
  localparam int unsigned DW = NC * SW;

  logic             clk;
  logic             reset;
  logic [SW-1:0]    param_threshold;
  logic [0:0]       s_tuser;
  logic             s_tlast;
  logic [DW-1:0]    s_tdata;
  logic             s_tvalid;
  logic             s_tready;
  logic [0:0]       m_tuser;
  logic             m_tlast;
  logic [CW-1:0]    m_tclass;
  logic [SW-1:0]    m_tscore;
  logic             m_tvalid;
  logic             m_tready;
  logic [NC*HW-1:0] hist_data;
  logic             hist_valid;

  video_mnist_argmax dut (
    .clk             (clk),
    .reset           (reset),
    .param_threshold (param_threshold),
    .s_axi4s_tuser   (s_tuser),
    .s_axi4s_tlast   (s_tlast),
    .s_axi4s_tdata   (s_tdata),
    .s_axi4s_tvalid  (s_tvalid),
    .s_axi4s_tready  (s_tready),
    .m_axi4s_tuser   (m_tuser),
    .m_axi4s_tlast   (m_tlast),
    .m_axi4s_tclass  (m_tclass),
    .m_axi4s_tscore  (m_tscore),
    .m_axi4s_tvalid  (m_tvalid),
    .m_axi4s_tready  (m_tready),
    .hist_data       (hist_data),
    .hist_valid      (hist_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          n_out    = 0;
  int          hist_pulses = 0;
  logic [NC*HW-1:0] hist_cap = '0;
  logic [63:0] exp_q [$];
  logic        hold_v = 1'b0;
  logic [63:0] hold_data = '0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: unsigned argmax, first maximum wins, reject below threshold.
  function automatic logic [63:0] model(input logic [DW-1:0] d, input logic [SW-1:0] thr,
                                        input logic u, input logic l);
    int          best;
    logic [SW-1:0] bs;
    logic [CW-1:0] cls;
    best = 0;
    bs   = d[SW-1:0];
    for (int k = 1; k < int'(NC); k++) begin
      if (d[k*SW +: SW] > bs) begin
        bs   = d[k*SW +: SW];
        best = k;
      end
    end
    cls = (bs < thr) ? 4'hF : CW'(best);
    return {49'b0, 1'b1, u, l, cls, bs};
  endfunction

  function automatic logic [DW-1:0] fill(input logic [SW-1:0] v);
    logic [DW-1:0] d;
    for (int k = 0; k < int'(NC); k++) d[k*SW +: SW] = v;
    return d;
  endfunction

  // Scoreboard monitor, sampled on the falling edge.
  always @(negedge clk) begin
    logic [63:0] out_vec;
    out_vec = {49'b0, m_tvalid, m_tuser, m_tlast, m_tclass, m_tscore};
    if (reset) begin
      exp_q.delete();
      hold_v = 1'b0;
    end else begin
      if (hist_valid) begin
        hist_pulses++;
        hist_cap = hist_data;
      end
      if (s_tvalid && s_tready) exp_q.push_back(model(s_tdata, param_threshold, s_tuser[0], s_tlast));
      if (hold_v) check_eq("hold_stable", out_vec, hold_data);
      if (m_tvalid && m_tready) begin
        if (exp_q.size() == 0) check_eq("unexpected_out", 64'(exp_q.size()), 64'd1);
        else check_eq("sb_out", out_vec, exp_q.pop_front());
        n_out++;
      end
      hold_v    = m_tvalid && !m_tready;
      hold_data = out_vec;
    end
  end

  task automatic do_reset(input int n);
    reset    = 1'b1;
    s_tvalid = 1'b0;
    repeat (n) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic send(input logic [DW-1:0] d, input logic u, input logic l, input logic [SW-1:0] thr);
    int n;
    bit acc;
    n   = 0;
    acc = 1'b0;
    s_tdata = d; s_tuser = u; s_tlast = l; param_threshold = thr; s_tvalid = 1'b1;
    while (!acc && n < 100) begin
      @(negedge clk);
      acc = s_tready;
      @(posedge clk);
      #1 n++;
    end
    s_tvalid = 1'b0;
    if (!acc) check_eq("send_timeout", 64'(acc), 64'd1);
  endtask

  // One beat with tready high; checks latency and the literal expected result.
  task automatic directed(input string tag, input logic [DW-1:0] d, input logic [SW-1:0] thr,
                          input logic [CW-1:0] ec, input logic [SW-1:0] es);
    int lat;
    m_tready = 1'b1;
    send(d, 1'b0, 1'b0, thr);
    lat = 1;
    @(negedge clk);
    while (!m_tvalid && lat < 20) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    check_eq({tag, "_lat"}, 64'(lat), 64'd5);
    check_eq({tag, "_class"}, 64'(m_tclass), 64'(ec));
    check_eq({tag, "_score"}, 64'(m_tscore), 64'(es));
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [DW-1:0] d;
    int sent, cyc, out0;
    bit pend, acc;

    reset = 1'b1; param_threshold = '0; s_tuser = '0; s_tlast = 1'b0;
    s_tdata = '0; s_tvalid = 1'b0; m_tready = 1'b0;
    do_reset(3);

    check_eq("rst_tvalid", 64'(m_tvalid), 64'd0);
    check_eq("rst_tclass", 64'(m_tclass), 64'd0);
    check_eq("rst_tscore", 64'(m_tscore), 64'd0);
    check_eq("rst_tuser",  64'(m_tuser),  64'd0);
    check_eq("rst_tlast",  64'(m_tlast),  64'd0);
    check_eq("rst_tready", 64'(s_tready), 64'd1);

    for (int k = 0; k < int'(NC); k++) d[k*SW +: SW] = SW'(k * 10);
    d[3*SW +: SW] = 8'd200;
    directed("basic", d, 8'd0, 4'd3, 8'd200);

    d = fill(8'd0);
    d[2*SW +: SW] = 8'd150;
    d[7*SW +: SW] = 8'd150;
    directed("tie", d, 8'd0, 4'd2, 8'd150);

    d = fill(8'd10);
    d[4*SW +: SW] = 8'd40;
    directed("thr_reject", d, 8'd50, 4'hF, 8'd40);
    directed("thr_equal", d, 8'd40, 4'd4, 8'd40);
    d = fill(8'd77);
    directed("all_equal", d, 8'd0, 4'd0, 8'd77);

    // Random valid/ready stream.
    out0 = n_out; sent = 0; cyc = 0; pend = 1'b0;
    while ((sent < 64 || pend) && cyc < 2000) begin
      m_tready = 1'($urandom_range(0, 1));
      if (!pend && sent < 64 && $urandom_range(0, 1) == 1) begin
        for (int k = 0; k < int'(NC); k++) s_tdata[k*SW +: SW] = SW'($urandom_range(0, 15) * 16);
        s_tuser         = 1'((sent % 16) == 0);
        s_tlast         = (sent % 4) == 3;
        param_threshold = ($urandom_range(0, 3) == 0) ? SW'($urandom_range(100, 255)) : 8'd0;
        s_tvalid        = 1'b1;
        pend            = 1'b1;
      end
      @(negedge clk);
      acc = s_tvalid && s_tready;
      @(posedge clk);
      #1 cyc++;
      if (acc) begin
        pend     = 1'b0;
        s_tvalid = 1'b0;
        sent++;
      end
    end
    m_tready = 1'b1;
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 100) begin
      @(posedge clk);
      #1 cyc++;
    end
    check_eq("drain_empty", 64'(exp_q.size()), 64'd0);
    check_eq("stream_count", 64'(n_out - out0), 64'd64);

    // Reset with three beats in flight.
    m_tready = 1'b1;
    d = fill(8'd5);
    for (int i = 0; i < 3; i++) begin
      d[i*SW +: SW] = 8'd99;
      send(d, 1'b0, 1'b0, 8'd0);
    end
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check_eq("post_rst_tvalid", 64'(m_tvalid), 64'd0);
    end
    @(posedge clk);
    #1;
    d = fill(8'd1);
    d[6*SW +: SW] = 8'd222;
    out0 = n_out;
    directed("after_rst", d, 8'd0, 4'd6, 8'd222);
    check_eq("after_rst_count", 64'(n_out - out0), 64'd1);

`ifdef VIDEO_MNIST_ARGMAX_HIST_EN
    do_reset(2);
    hist_pulses = 0;
    m_tready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (i < 10) begin
        d = fill(8'd10);
        d[1*SW +: SW] = 8'd100;
      end else begin
        d = fill(8'd20);
      end
      send(d, i == 0, (i % 4) == 3, 8'd50);
    end
    d = fill(8'd0);
    d[5*SW +: SW] = 8'd60;
    send(d, 1'b1, 1'b0, 8'd0);
    repeat (12) @(posedge clk);
    #1;
    check_eq("hist_pulses", 64'(hist_pulses), 64'd1);
    for (int k = 0; k < int'(NC); k++) begin
      check_eq($sformatf("hist_cnt%0d", k), 64'(hist_cap[k*HW +: HW]), (k == 1) ? 64'd10 : 64'd0);
    end
`else
    check_eq("hist_pulses", 64'(hist_pulses), 64'd0);
    for (int k = 0; k < int'(NC); k++) begin
      check_eq($sformatf("hist_cnt%0d", k), 64'(hist_data[k*HW +: HW]), 64'd0);
    end
`endif

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
